// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side controller for a gray-pointer FIFO: round-robin write arbiter,
// binary/gray write pointers, registered full flag. Option: GRAY_FIFO_LEVEL_EN.
module gray_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic                  i_halt,
    input  logic [ADDR_WIDTH:0]   i_rd_gray_sync,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [ADDR_WIDTH:0]   o_wr_gray,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_level
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         w_win;
    logic [PW-1:0]         w_rr_next;
    logic                  w_found;
    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_gnt_onehot;
    logic [NUM_REQ-1:0]    r_gnt;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_wr_bin;
    logic [ADDR_WIDTH:0]   r_wr_gray;
    logic                  r_full;
    logic [ADDR_WIDTH:0]   w_bin_next;
    logic [ADDR_WIDTH:0]   w_gray_next;
    logic [ADDR_WIDTH:0]   w_full_cmp;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= RUN;
        else          r_state <= w_state_next;
    end

    // Next state: halt outranks full; grants only when heading into RUN
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN: begin
                if (i_halt)      w_state_next = HALT;
                else if (r_full) w_state_next = STALL;
            end
            STALL: begin
                if (i_halt)       w_state_next = HALT;
                else if (!r_full) w_state_next = RUN;
            end
            HALT: begin
                if (!i_halt) w_state_next = r_full ? STALL : RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    // Round-robin scan: first asserted request at or after r_rr_ptr
    always_comb begin
        logic [PW:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (v_sum >= (PW+1)'(NUM_REQ))
                v_sum = v_sum - (PW+1)'(NUM_REQ);
            if (!w_found && i_req[v_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_sum[PW-1:0];
            end
        end
    end

    assign w_grant      = (w_state_next == RUN) && w_found;
    assign w_rr_next    = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

    assign w_bin_next  = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_grant};
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    assign w_full_cmp  = {~i_rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                          i_rd_gray_sync[ADDR_WIDTH-2:0]};

    // Grant, write strobe, pointers and full flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_full    <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            r_gnt     <= w_grant ? w_gnt_onehot : '0;
            r_wr_en   <= w_grant;
            r_wr_bin  <= w_bin_next;
            r_wr_gray <= w_gray_next;
            r_full    <= (w_gray_next == w_full_cmp);
            if (w_grant) begin
                r_wr_addr <= r_wr_bin[ADDR_WIDTH-1:0];
                r_rr_ptr  <= w_rr_next;
            end
        end
    end

    assign o_gnt     = r_gnt;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_gray = r_wr_gray;
    assign o_full    = r_full;

`ifdef GRAY_FIFO_LEVEL_EN
    logic [ADDR_WIDTH:0] w_rd_bin;
    logic [ADDR_WIDTH:0] r_level;

    // Gray-to-binary decode of the synchronized read pointer
    always_comb begin
        logic v_acc;
        w_rd_bin           = '0;
        v_acc              = i_rd_gray_sync[ADDR_WIDTH];
        w_rd_bin[ADDR_WIDTH] = v_acc;
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            v_acc       = v_acc ^ i_rd_gray_sync[i];
            w_rd_bin[i] = v_acc;
        end
    end

    // Occupancy seen from the write side, refreshed every cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_level <= '0;
        else          r_level <= w_bin_next - w_rd_bin;
    end

    assign o_level = r_level;
`else
    assign o_level = '0;
`endif

endmodule

// File: doc/gray_fifo_wr_ctrl.md
# gray_fifo_wr_ctrl

Write-side controller for a gray-pointer FIFO, running in a single write clock domain. It round-robin arbitrates NUM_REQ write requesters onto one FIFO write port and advances the binary and gray write pointers. It computes `full` against the read-side gray pointer, which arrives already synchronized into this domain, and exports the registered gray write pointer for crossing to the read domain.

## Interface
- ADDR_WIDTH, 4, log2 of FIFO depth; pointers are ADDR_WIDTH+1 bits.
- NUM_REQ, 2, number of write requesters (2..8).

- clk  input  1  write-domain clock.
- rst_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; held until granted.
- halt  input  1  stops new grants while high.
- rd_gray_sync  input  ADDR_WIDTH+1  read gray pointer, already synchronized to clk.
- gnt  output  NUM_REQ  registered one-hot grant, one-cycle pulse.
- wr_en  output  1  registered write strobe; equals |gnt.
- wr_addr  output  ADDR_WIDTH  RAM write address, valid with wr_en.
- wr_gray  output  ADDR_WIDTH+1  registered gray write pointer, for CDC to the read domain.
- full  output  1  registered full flag.
- level  output  ADDR_WIDTH+1  write-side occupancy estimate.

## Operation
- Reset (rst_n low at a posedge) sets all outputs to 0: gnt, wr_en, wr_addr, wr_gray, full, level.
- Reset also clears wr_bin, sets rr_ptr to 0 and sets the state to RUN.
- Reset mid-operation aborts any pending grant; no wr_en is issued in the cycle after reset.
- FSM states:
  - RUN: grants are allowed.
  - STALL: full=1; no grants.
  - HALT: halt=1; no grants.
- FSM transitions:
  - RUN→HALT on halt. HALT takes priority over STALL.
  - RUN→STALL on full.
  - STALL→RUN when full clears.
  - HALT→RUN, or HALT→STALL if full, when halt drops.
- Arbitration, evaluated in RUN with full=0 and |req:
  - The winner is the first asserted req at or after rr_ptr, scanning upward modulo NUM_REQ.
  - At the next edge: gnt[winner]=1, wr_en=1, wr_addr=wr_bin[ADDR_WIDTH-1:0] (pre-increment), wr_bin increments by 1, and rr_ptr becomes (winner+1) mod NUM_REQ.
- A requester whose req is still high after its gnt is treated as a new request and rearbitrated. At most one grant is issued per cycle.
- Pointer arithmetic:
  - wr_bin is ADDR_WIDTH+1 bits and wraps modulo 2^(ADDR_WIDTH+1).
  - wr_gray = next_bin ^ (next_bin >> 1), registered on the same edge as wr_bin.
  - Every transition of wr_gray, including the wrap from all-ones binary to 0, changes exactly one bit.
  - wr_gray is stable in any cycle without wr_en.
- Full:
  - full is registered from the next gray pointer.
  - full = (next_gray == {~rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_sync[ADDR_WIDTH-2:0]}).
  - Because full is registered, a grant is never issued in the cycle after the write that fills the FIFO.
- Simultaneous events:
  - If rd_gray_sync advances in the same cycle as a write that would fill the FIFO, full is evaluated against the new rd_gray_sync.
  - halt asserted in the same cycle as req suppresses that grant.

## Timing
- Latency from req sampled to gnt/wr_en is 1 cycle.
- Sustained throughput is 1 write per cycle while not full.
- full asserts on the same edge as the write that makes the FIFO full.
- full deasserts 1 cycle after rd_gray_sync shows space.
- wr_gray and wr_bin update on the same edge as the corresponding wr_en.

## Configuration
- GRAY_FIFO_LEVEL_EN defined:
  - rd_gray_sync is gray-decoded to binary (MSB copied, then XOR accumulation downward).
  - level is registered as wr_bin_next − rd_bin, modulo 2^(ADDR_WIDTH+1), and updates every cycle.
  - level equals 2^ADDR_WIDTH exactly when full=1.
- GRAY_FIFO_LEVEL_EN undefined: level is tied to 0 and no decoder is built.

## Test plan
All scenarios use ADDR_WIDTH=2 and NUM_REQ=2.

- Reset: hold rst_n=0 for 2 cycles with req=2'b11 → gnt=0, wr_en=0, wr_gray=3'b000, full=0, level=0 on every cycle of reset and on the first edge after it.
- Round-robin: req=2'b11 held, rd_gray_sync=0 → gnt sequence 01, 10, 01, 10; wr_addr 0, 1, 2, 3; wr_gray 001, 011, 010, 110.
- Full:
  - Continue the round-robin scenario → full=1 on the edge of the 4th write; no 5th grant while rd_gray_sync=000.
  - Drive rd_gray_sync=001 → full=0 one cycle later, then exactly one grant is issued.
- Wrap: run 8 write/read pairs with the reader keeping pace → wr_gray passes 100 then returns to 000, and $countones(Δwr_gray)==1 on every write.
- Halt: assert halt with req=2'b01 for 3 cycles → no gnt during those cycles; the first gnt appears 1 cycle after halt drops.
- Level (macro defined): after 3 writes with rd_gray_sync=011 (binary 2) → level=1.
